// File: rtl/board_pkg.sv
// Shared board-level constants for the DE10-Lite pushbutton front end.
//   DEFAULT_DEBOUNCE_CYCLES : 10 ms of stability at 50 MHz
//   KEY_PRESSED             : electrical level of a pressed (active-low) key
//   KEY_UP_IDX/KEY_DOWN_IDX : which KEY bit counts up / down
package board_pkg;
  localparam int   DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam logic KEY_PRESSED             = 1'b0;
  localparam int   KEY_UP_IDX              = 0;
  localparam int   KEY_DOWN_IDX            = 1;
endpackage

// File: rtl/key_debouncer.sv
// Single-key front end: two-flop synchroniser, debounce filter and
// press-pulse generator.
// Ports:
//   MAX10_CLK1_50 : system clock
//   RESET         : synchronous, active-high reset
//   key_n         : raw active-low pushbutton, asynchronous to the clock
//   press         : one-cycle pulse when the debounced level becomes pressed
module key_debouncer
  import board_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic MAX10_CLK1_50,
  input  logic RESET,
  input  logic key_n,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;
  logic          synced;

  assign synced = sync_q[1];

  // The counter only runs while the synced level disagrees with the accepted
  // level; any return to the accepted level clears it, so a glitch restarts
  // the full debounce window.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (synced != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = synced;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    // Pulse only on the released-to-pressed transition of the accepted level.
    press_d = (stable_q != KEY_PRESSED) && (stable_d == KEY_PRESSED);
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (RESET) begin
      sync_q   <= 2'b11;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], key_n};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/key_event_counter.sv
// Pushbutton up/down counter feeding the two-digit 7-segment decoder.
// KEY[0] counts up, KEY[1] counts down, both wrap between 0 and MAX_COUNT;
// LOAD takes a (clamped) value from the switches.
// Ports:
//   MAX10_CLK1_50 : 50 MHz system clock
//   RESET         : synchronous, active-high reset
//   KEY[1:0]      : raw active-low pushbuttons
//   LOAD          : synchronous load strobe (SW[9])
//   LOAD_VAL      : value to load (SW[3:0])
//   COUNT         : current count, replaces SW[3:0] at the decoder input
//   PRESS[1:0]    : one-cycle press pulses, [0] = up key, [1] = down key
module key_event_counter
  import board_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int MAX_COUNT       = 15,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             MAX10_CLK1_50,
  input  logic             RESET,
  input  logic [1:0]       KEY,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  output logic [WIDTH-1:0] COUNT,
  output logic [1:0]       PRESS
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

  logic [1:0]       press_w;
  logic [WIDTH-1:0] count_q, count_d;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_key
      key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debouncer (
        .MAX10_CLK1_50(MAX10_CLK1_50),
        .RESET        (RESET),
        .key_n        (KEY[gi]),
        .press        (press_w[gi])
      );
    end
  endgenerate

  // Load beats key pulses; opposite pulses in the same cycle cancel.
  always_comb begin
    count_d = count_q;
    if (LOAD) begin
      count_d = (LOAD_VAL > MAX_V) ? MAX_V : LOAD_VAL;
    end else if (press_w[KEY_UP_IDX] && press_w[KEY_DOWN_IDX]) begin
      count_d = count_q;
    end else if (press_w[KEY_UP_IDX]) begin
      count_d = (count_q == MAX_V) ? '0 : count_q + WIDTH'(1);
    end else if (press_w[KEY_DOWN_IDX]) begin
      count_d = (count_q == '0) ? MAX_V : count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (RESET) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign COUNT = count_q;
  assign PRESS = press_w;

endmodule
